// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  aes_pkg
//  Shared AES types, constants and GF(2^8) helpers for the inverse cipher.
//  Revision: 1.0
// ============================================================================
package aes_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        KEXP  = 3'd1,
        INIT  = 3'd2,
        ROUND = 3'd3,
        DONE  = 3'd4
    } state_e;

    function automatic logic [7:0] rcon(input logic [3:0] i);
        case (i)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        gmul = p;
    endfunction

    // Multiplicative inverse as x^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] t;
        logic [7:0] r;
        t = x;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            t = gmul(t, t);
            r = gmul(r, t);
        end
        gf_inv = r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        rotl8 = (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        rot_word = {w[23:0], w[31:24]};
    endfunction

    // Byte i of a block sits at bits [127-8i -: 8]; row = i%4, column = i/4.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8];
            end
        end
        inv_shift_rows = o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            o[119 - 32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            o[111 - 32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            o[103 - 32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        inv_mix_columns = o;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_inv_sbox.sv
`default_nettype none
// ============================================================================
//  aes_inv_sbox
//  Inverse AES S-box (combinational): inverse affine map, then GF inverse.
//  Revision: 1.0
// ============================================================================
module aes_inv_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);
    logic [7:0] w_aff;

    assign w_aff = rotl8(a_i, 1) ^ rotl8(a_i, 3) ^ rotl8(a_i, 6) ^ 8'h05;
    assign y_o   = gf_inv(w_aff);
endmodule
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
//  aes_sbox
//  Forward AES S-box (combinational), used for key-schedule SubWord.
//  Revision: 1.0
// ============================================================================
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);
    logic [7:0] w_inv;

    assign w_inv = gf_inv(a_i);
    assign y_o   = w_inv ^ rotl8(w_inv, 1) ^ rotl8(w_inv, 2) ^ rotl8(w_inv, 3)
                 ^ rotl8(w_inv, 4) ^ 8'h63;
endmodule
`default_nettype wire

// File: rtl/aes_inv_cipher_seq.sv
`default_nettype none
// ============================================================================
//  aes_inv_cipher_seq
//  Iterative AES-128 decryptor: one inverse round per clock, round keys
//  regenerated backwards from k10, with an optional last-key k10 cache.
//  Revision: 1.0
// ============================================================================
module aes_inv_cipher_seq
    import aes_pkg::*;
#(
    parameter int NR        = 10,
    parameter bit CACHE_KEY = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] in,
    input  logic [0:127] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out,
    output logic [4:0]   round,
    output logic         busy
);
    if (NR != 10) begin : g_nr_check
        $error("aes_inv_cipher_seq: only NR=10 is supported");
    end

    state_e       state_q, state_d;
    logic [127:0] s_q, s_d;
    logic [127:0] k_q, k_d;
    logic [127:0] out_q, out_d;
    logic [4:0]   round_q, round_d;
    logic [3:0]   kcnt_q, kcnt_d;
    logic [127:0] cache_key_q, cache_key_d;
    logic [127:0] cache_k10_q, cache_k10_d;
    logic         cache_vld_q, cache_vld_d;

    logic [127:0] w_in, w_key;
    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic [31:0]  w_iw1, w_iw2, w_iw3, w_iw0;
    logic [31:0]  w_f0, w_f1, w_f2, w_f3;
    logic [31:0]  w_sb_in, w_sb_out;
    logic [7:0]   w_rc;
    logic [127:0] w_k_fwd, w_k_inv;
    logic [127:0] w_sr, w_isb, w_ark, w_rnd;

    assign w_in  = in;
    assign w_key = key;

    assign w_w0 = k_q[127:96];
    assign w_w1 = k_q[95:64];
    assign w_w2 = k_q[63:32];
    assign w_w3 = k_q[31:0];

    assign w_iw3 = w_w3 ^ w_w2;
    assign w_iw2 = w_w2 ^ w_w1;
    assign w_iw1 = w_w1 ^ w_w0;

    // One SubWord unit serves both directions: forward expansion in KEXP,
    // backward regeneration in INIT/ROUND.
    assign w_sb_in = (state_q == KEXP) ? rot_word(w_w3) : rot_word(w_iw3);
    assign w_rc    = rcon((state_q == KEXP) ? (kcnt_q + 4'd1) : round_q[3:0]);

    for (genvar j = 0; j < 4; j++) begin : g_ksbox
        aes_sbox u_sbox (
            .a_i (w_sb_in[31 - 8*j -: 8]),
            .y_o (w_sb_out[31 - 8*j -: 8])
        );
    end

    assign w_f0    = w_w0 ^ w_sb_out ^ {w_rc, 24'h0};
    assign w_f1    = w_w1 ^ w_f0;
    assign w_f2    = w_w2 ^ w_f1;
    assign w_f3    = w_w3 ^ w_f2;
    assign w_k_fwd = {w_f0, w_f1, w_f2, w_f3};

    assign w_iw0   = w_w0 ^ w_sb_out ^ {w_rc, 24'h0};
    assign w_k_inv = {w_iw0, w_iw1, w_iw2, w_iw3};

    assign w_sr = inv_shift_rows(s_q);

    for (genvar b = 0; b < 16; b++) begin : g_isbox
        aes_inv_sbox u_inv_sbox (
            .a_i (w_sr[127 - 8*b -: 8]),
            .y_o (w_isb[127 - 8*b -: 8])
        );
    end

    assign w_ark = w_isb ^ k_q;
    assign w_rnd = (round_q == 5'd0) ? w_ark : inv_mix_columns(w_ark);

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        k_d         = k_q;
        out_d       = out_q;
        round_d     = round_q;
        kcnt_d      = kcnt_q;
        cache_key_d = cache_key_q;
        cache_k10_d = cache_k10_q;
        cache_vld_d = cache_vld_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    s_d     = w_in;
                    round_d = 5'd10;
                    if (CACHE_KEY && cache_vld_q && (w_key == cache_key_q)) begin
                        k_d     = cache_k10_q;
                        state_d = INIT;
                    end else begin
                        k_d         = w_key;
                        cache_key_d = w_key;
                        cache_vld_d = 1'b0;
                        kcnt_d      = 4'd0;
                        state_d     = KEXP;
                    end
                end
            end
            KEXP: begin
                k_d    = w_k_fwd;
                kcnt_d = kcnt_q + 4'd1;
                if (kcnt_q == 4'd9) begin
                    cache_k10_d = w_k_fwd;
                    cache_vld_d = CACHE_KEY;
                    state_d     = INIT;
                end
            end
            INIT: begin
                s_d     = s_q ^ k_q;
                k_d     = w_k_inv;
                round_d = 5'd9;
                state_d = ROUND;
            end
            ROUND: begin
                s_d = w_rnd;
                if (round_q != 5'd0) begin
                    k_d     = w_k_inv;
                    round_d = round_q - 5'd1;
                end else begin
                    out_d   = w_ark;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            s_q         <= '0;
            k_q         <= '0;
            out_q       <= '0;
            round_q     <= '0;
            kcnt_q      <= '0;
            cache_key_q <= '0;
            cache_k10_q <= '0;
            cache_vld_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            k_q         <= k_d;
            out_q       <= out_d;
            round_q     <= round_d;
            kcnt_q      <= kcnt_d;
            cache_key_q <= cache_key_d;
            cache_k10_q <= cache_k10_d;
            cache_vld_q <= cache_vld_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == KEXP) || (state_q == INIT) || (state_q == ROUND);
    assign out       = out_q;
    assign round     = round_q;
endmodule
`default_nettype wire

// File: tb/tb_aes_inv_cipher_seq.sv
`default_nettype none
// ============================================================================
//  tb_aes_inv_cipher_seq
//  Scoreboarded bench for the iterative AES-128 decryptor (FIPS-197 vectors).
//  Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_aes_inv_cipher_seq;
    import aes_pkg::*;

    localparam logic [127:0] c_T1_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] c_T1_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_T1_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] c_T1_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] c_T2_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] c_T2_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_T2_PT  = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [0:127] din = '0;
    logic [0:127] key = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [0:127] dout;
    logic [4:0]   round;
    logic         busy;

    int vectors     = 0;
    int miscompares = 0;
    int edge_cnt    = 0;
    bit kexp_seen   = 1'b0;
    bit seen        = 1'b0;

    typedef struct {
        logic [127:0] pt;
        int           lat;
        int           acc;
    } exp_t;
    exp_t sb_q[$];

    aes_inv_cipher_seq #(.NR(10), .CACHE_KEY(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (din),
        .key       (key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (dout),
        .round     (round),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt++;

    always @(negedge clk) if (dut.state_q == KEXP) kexp_seen = 1'b1;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: first cycle of each out_valid pulse pops one expectation.
    always @(negedge clk) begin
        if (!out_valid) begin
            seen = 1'b0;
        end else if (!seen) begin
            seen = 1'b1;
            if (sb_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_output: got %h expected no output", dout);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("plaintext", dout, e.pt);
                chk("latency", 128'(edge_cnt - e.acc), 128'(e.lat));
            end
        end
    end

    task automatic send(input logic [127:0] ct, input logic [127:0] k, input logic [127:0] pt,
                        input int lat, input bit expect_out);
        int n;
        n = 0;
        @(negedge clk);
        din      = ct;
        key      = k;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 128'(in_ready), 128'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        din      = ~ct;
        key      = ~k;
        if (expect_out) sb_q.push_back('{pt, lat, edge_cnt});
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) chk("out_timeout", 128'(out_valid), 128'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] held;
        int n;

        repeat (3) @(negedge clk);
        chk("rst_in_ready",  128'(in_ready),  128'd1);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_out",       dout,            128'd0);
        chk("rst_round",     128'(round),     128'd0);
        chk("rst_busy",      128'(busy),      128'd0);
        rst_n = 1'b1;

        // T1 with full expansion, plus key-schedule probe
        send(c_T1_CT, c_T1_KEY, c_T1_PT, 21, 1'b1);
        @(negedge clk);
        chk("t1_busy",  128'(busy),  128'd1);
        chk("t1_round", 128'(round), 128'd10);
        wait_out();
        @(negedge clk);
        chk("t6_k10", dut.cache_k10_q, c_T1_K10);

        // T2 then T3 (same key, cache hit)
        send(c_T2_CT, c_T2_KEY, c_T2_PT, 21, 1'b1);
        wait_out();
        @(negedge clk);
        kexp_seen = 1'b0;
        send(c_T2_CT, c_T2_KEY, c_T2_PT, 11, 1'b1);
        wait_out();
        @(negedge clk);
        chk("t3_no_kexp", 128'(kexp_seen), 128'd0);

        // T4 backpressure on the output
        out_ready = 1'b0;
        send(c_T1_CT, c_T1_KEY, c_T1_PT, 21, 1'b1);
        wait_out();
        held = dout;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_out_stable",  dout,                held);
            chk("t4_valid_held",  128'(out_valid),     128'd1);
            chk("t4_in_ready_lo", 128'(in_ready),      128'd0);
        end
        out_ready = 1'b1;
        chk("t4_in_ready_pulse", 128'(in_ready), 128'd0);
        @(negedge clk);
        out_ready = 1'b1;
        chk("t4_in_ready_after", 128'(in_ready),  128'd1);
        chk("t4_valid_dropped",  128'(out_valid), 128'd0);

        // T5 asynchronous reset in mid-flight (cache hit run, no output expected)
        send(c_T1_CT, c_T1_KEY, c_T1_PT, 11, 1'b0);
        n = 0;
        while (round != 5'd5 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t5_reach_round5", 128'(round), 128'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_out_valid", 128'(out_valid), 128'd0);
        chk("t5_out",       dout,            128'd0);
        chk("t5_in_ready",  128'(in_ready),  128'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Cache was invalidated by reset: full expansion again
        send(c_T1_CT, c_T1_KEY, c_T1_PT, 21, 1'b1);
        wait_out();
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 128'(sb_q.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
